// File: rtl/mbinit_pkg.sv
// Shared types and constants for the MBINIT sideband TX arbitration slice.
package mbinit_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } arbState_e;

  localparam int REQ_MOD = 0;
  localparam int REQ_PAR = 1;

  // Data field: {voltage_swing[4:0], max_data_rate[2:0], clock_mode, clock_phase}
  localparam int CLK_PHASE_OFS = 0;
  localparam int CLK_MODE_OFS  = 1;
  localparam int MAX_RATE_OFS  = 2;
  localparam int MAX_RATE_W    = 3;
  localparam int VSWING_OFS    = 5;
  localparam int VSWING_W      = 5;

  function automatic logic [9:0] packParamData(input logic [4:0] vSwing, input logic [2:0] maxRate,
                                               input logic clkMode, input logic clkPhase);
    logic [9:0] d;
    d = '0;
    d[CLK_PHASE_OFS] = clkPhase;
    d[CLK_MODE_OFS] = clkMode;
    d[MAX_RATE_OFS +: MAX_RATE_W] = maxRate;
    d[VSWING_OFS +: VSWING_W] = vSwing;
    return d;
  endfunction

endpackage

// File: rtl/mbinit_sb_tx_arbiter_if.sv
// Handshake bundle between the PARAM FSMs, the arbiter and the sideband TX encoder.
interface mbinit_sb_tx_arbiter_if #(
  parameter int DATA_W = 10
);
  logic              i_en;
  logic              i_mod_req;
  logic              i_par_req;
  logic [3:0]        i_mod_msg;
  logic [3:0]        i_par_msg;
  logic              i_mod_has_data;
  logic              i_par_has_data;
  logic [DATA_W-1:0] i_mod_data;
  logic [DATA_W-1:0] i_par_data;
  logic              i_sb_busy;
  logic              i_falling_edge_busy;
  logic              o_mod_gnt;
  logic              o_par_gnt;
  logic              o_mod_done;
  logic              o_par_done;
  logic              o_sb_valid;
  logic [3:0]        o_sb_msg;
  logic              o_sb_data_valid;
  logic [DATA_W-1:0] o_sb_data;
  logic              o_timeout_err;

  modport slave (
    input  i_en, i_mod_req, i_par_req, i_mod_msg, i_par_msg, i_mod_has_data, i_par_has_data,
           i_mod_data, i_par_data, i_sb_busy, i_falling_edge_busy,
    output o_mod_gnt, o_par_gnt, o_mod_done, o_par_done, o_sb_valid, o_sb_msg,
           o_sb_data_valid, o_sb_data, o_timeout_err
  );

  modport master (
    output i_en, i_mod_req, i_par_req, i_mod_msg, i_par_msg, i_mod_has_data, i_par_has_data,
           i_mod_data, i_par_data, i_sb_busy, i_falling_edge_busy,
    input  o_mod_gnt, o_par_gnt, o_mod_done, o_par_done, o_sb_valid, o_sb_msg,
           o_sb_data_valid, o_sb_data, o_timeout_err
  );
endinterface

// File: rtl/mbinit_sb_timer.sv
// Saturating transfer timer; tcDone flags the cycle in which the count reaches TIMEOUT_CYCLES.
module mbinit_sb_timer #(
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tcDone
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign tcDone = en && (count >= LIMIT_M1);
endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin owner of the sideband TX channel shared by the MBINIT PARAM requester and responder.
// state     | meaning
// IDLE      | arbitrate pending requests once the sideband is free
// ISSUE     | latched message presented, waiting for busy to rise
// WAIT_DONE | sideband transmitting, waiting for busy falling edge
// DONE      | one-cycle completion pulse to the owner
module mbinit_sb_tx_arbiter
  import mbinit_pkg::*;
#(
  parameter int DATA_W         = 10,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input logic CLK,
  input logic rst_n,
  mbinit_sb_tx_arbiter_if.slave sb
);
  arbState_e         state, nextState;
  logic              ownerPar, nextOwnerPar;
  logic              lastGntPar, nextLastGntPar;
  logic [3:0]        msgLatch, nextMsg;
  logic              hasDataLatch, nextHasData;
  logic [DATA_W-1:0] dataLatch, nextData;
  logic              winPar, timeoutPulse, tcDone, active;
  logic [1:0]        reqVec;

  assign reqVec[REQ_MOD] = sb.i_mod_req;
  assign reqVec[REQ_PAR] = sb.i_par_req;

  mbinit_sb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uTimer (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .clr    (state == IDLE),
    .en     (sb.i_en && ((state == ISSUE) || (state == WAIT_DONE))),
    .tcDone (tcDone)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ownerPar     <= 1'b0;
      lastGntPar   <= 1'b1;
      msgLatch     <= '0;
      hasDataLatch <= 1'b0;
      dataLatch    <= '0;
    end else begin
      state        <= nextState;
      ownerPar     <= nextOwnerPar;
      lastGntPar   <= nextLastGntPar;
      msgLatch     <= nextMsg;
      hasDataLatch <= nextHasData;
      dataLatch    <= nextData;
    end
  end

  always_comb begin
    nextState      = state;
    nextOwnerPar   = ownerPar;
    nextLastGntPar = lastGntPar;
    nextMsg        = msgLatch;
    nextHasData    = hasDataLatch;
    nextData       = dataLatch;
    winPar         = 1'b0;
    timeoutPulse   = 1'b0;
    if (!sb.i_en) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!sb.i_sb_busy && (reqVec != 2'b00)) begin
            // On a tie the side that did not own the channel last wins.
            winPar       = reqVec[REQ_PAR] && (!reqVec[REQ_MOD] || !lastGntPar);
            nextOwnerPar = winPar;
            nextMsg      = winPar ? sb.i_par_msg : sb.i_mod_msg;
            nextHasData  = winPar ? sb.i_par_has_data : sb.i_mod_has_data;
            nextData     = winPar ? sb.i_par_data : sb.i_mod_data;
            nextState    = ISSUE;
          end
        end
        ISSUE: begin
          if (tcDone) begin
            nextState      = IDLE;
            timeoutPulse   = 1'b1;
            nextLastGntPar = ownerPar;
          end else if (sb.i_sb_busy) begin
            nextState = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (sb.i_falling_edge_busy) begin
            nextState = DONE;
          end else if (tcDone) begin
            nextState      = IDLE;
            timeoutPulse   = 1'b1;
            nextLastGntPar = ownerPar;
          end
        end
        DONE: begin
          nextState      = IDLE;
          nextLastGntPar = ownerPar;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  assign active = (nextState != IDLE);

  // Outputs are registered from the next-state view so they line up with the state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sb.o_mod_gnt       <= 1'b0;
      sb.o_par_gnt       <= 1'b0;
      sb.o_mod_done      <= 1'b0;
      sb.o_par_done      <= 1'b0;
      sb.o_sb_valid      <= 1'b0;
      sb.o_sb_msg        <= 4'h0;
      sb.o_sb_data_valid <= 1'b0;
      sb.o_sb_data       <= '0;
      sb.o_timeout_err   <= 1'b0;
    end else begin
      sb.o_mod_gnt       <= active && !nextOwnerPar;
      sb.o_par_gnt       <= active && nextOwnerPar;
      sb.o_mod_done      <= (nextState == DONE) && !nextOwnerPar;
      sb.o_par_done      <= (nextState == DONE) && nextOwnerPar;
      sb.o_sb_valid      <= (nextState == ISSUE);
      sb.o_sb_msg        <= active ? nextMsg : 4'h0;
      sb.o_sb_data_valid <= ((nextState == ISSUE) || (nextState == WAIT_DONE)) && nextHasData;
      sb.o_sb_data       <= active ? nextData : '0;
      sb.o_timeout_err   <= timeoutPulse;
    end
  end
endmodule

// File: doc/mbinit_sb_tx_arbiter.md
# mbinit_sb_tx_arbiter

Shares the single sideband TX message channel between the MBINIT parameter-exchange requester FSM (module side) and responder FSM (partner side). Each side raises a level request with a 4-bit message code and optional data field. The arbiter grants one side at a time, holds the message stable until the sideband accepts it (busy rises), and reports completion on busy's falling edge. It sits between the two PARAM FSMs and the sideband TX encoder. It replaces ad-hoc valid-priority muxing with a sequenced, fair, timeout-guarded handshake.

## Interface
- DATA_W, 10: data field width, packed {voltage_swing[4:0], max_data_rate[2:0], clock_mode, clock_phase}
- TIMEOUT_CYCLES, 8000: max cycles from issue to falling edge of busy before abort
- CLK  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  MBINIT PARAM substate active; low aborts to IDLE synchronously
- i_mod_req / i_par_req  in  1 each  level request; held until matching done
- i_mod_msg / i_par_msg  in  4 each  message code
- i_mod_has_data / i_par_has_data  in  1 each  message carries data field
- i_mod_data / i_par_data  in  DATA_W each  data field
- i_sb_busy  in  1  sideband TX busy
- i_falling_edge_busy  in  1  one-cycle pulse on busy 1->0
- o_mod_gnt / o_par_gnt  out  1 each  level; side currently owns channel (ISSUE, WAIT_DONE, DONE)
- o_mod_done / o_par_done  out  1 each  one-cycle completion pulse
- o_sb_valid  out  1  message presented to sideband
- o_sb_msg  out  4  latched message code
- o_sb_data_valid  out  1  data field valid
- o_sb_data  out  DATA_W  latched data field
- o_timeout_err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, ISSUE, WAIT_DONE, DONE.
- IDLE: arbitrates when i_en=1, i_sb_busy=0, and at least one request is high.
  - Single request: that side wins.
  - Both: round-robin; winner is the side not granted last. Pointer resets to "partner last", so the module wins the first tie.
  - On a win, latch msg/has_data/data, set gnt, go ISSUE.
- ISSUE: o_sb_valid=1 and o_sb_msg/data come from latches; requester input changes are ignored. i_sb_busy=1 -> WAIT_DONE, o_sb_valid drops.
- WAIT_DONE: i_falling_edge_busy -> DONE.
- DONE: one cycle. Pulse the winner's done, update the round-robin pointer, go IDLE. The requester must drop req in the cycle after it sees done.
- Timeout: counter clears on entry to ISSUE and counts through ISSUE and WAIT_DONE. When it reaches TIMEOUT_CYCLES:
  - pulse o_timeout_err, go IDLE;
  - no done pulse, pointer still advances;
  - falling edge in the same cycle as timeout wins, so completion is normal.
- i_en=0 in any state: next cycle in IDLE; all outputs are cleared, latches are kept, pointer is unchanged, no done or error pulse.
- o_sb_data_valid = latched has_data while o_sb_valid or WAIT_DONE; 0 otherwise.

## Timing
- All outputs are registered.
- Reset values: state IDLE, every gnt/done/valid/err output 0, o_sb_msg 4'h0, o_sb_data 0, pointer = partner, counter 0.
- Request sampled in IDLE at cycle t -> gnt and o_sb_valid high at t+1.
- Busy high sampled at t -> o_sb_valid low at t+1.
- Falling-edge pulse at t -> DONE and done pulse at t+1 -> IDLE at t+2. Minimum back-to-back gap between grants: 1 IDLE cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- Reset mid-transfer: immediate return to reset values; no pulses are generated.

## Structure
- Shared package mbinit_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_DONE, DONE);
  - requester index constants REQ_MOD=0, REQ_PAR=1;
  - data-field bit offsets for voltage swing, max data rate, clock mode and clock phase.
- One sub-module: mbinit_sb_timer, a clear/enable saturating counter with a done flag, parameterised by TIMEOUT_CYCLES.

## Test plan
- Module only: req, msg=4'h1, data=10'h2A5, busy rises 3 cycles after valid, falls 5 cycles later.
  - Required: o_sb_valid 1 cycle after req, msg 4'h1 and data 10'h2A5 held stable.
  - Required: o_mod_done pulses exactly once, 1 cycle after the falling edge.
- Both request in the same cycle, twice in a row. Required: the first grant goes to module, the second to partner, and their msg codes appear in that order.
- i_sb_busy=1 when a request arrives. Required: no grant until busy=0, then grant on the next cycle.
- TIMEOUT_CYCLES=16, busy never rises.
  - Required: o_timeout_err pulses 16 cycles after ISSUE entry, no done pulse, back in IDLE.
  - Variant: falling edge lands on cycle 16 -> done pulses, no error.
- i_en drops during WAIT_DONE. Required: IDLE next cycle, all outputs 0, no pulses.
- rst_n asserted mid-ISSUE. Required: all outputs at reset values immediately, and the first tie after release goes to module.
